// File: rtl/write_back_stage.sv
// Write-back pipeline stage: picks ALU or memory data, applies big-endian load
// extension, and registers the register-file write (data, index, enable).
module write_back_stage #(
    parameter int N         = 32,
    parameter int RF_ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         data_from_memory,
    input  logic [N-1:0]         data_from_alu,
    input  logic [0:0]           select_wb,
    input  logic [2:0]           load_type,
    input  logic [1:0]           addr_lsb,
    input  logic [RF_ADDR_W-1:0] rd_in,
    input  logic                 rf_we_in,
    input  logic                 stall,
    input  logic                 flush,
    output logic [N-1:0]         data_to_rf,
    output logic [RF_ADDR_W-1:0] rd_out,
    output logic                 rf_we_out
);

    // Big-endian lanes: byte 0 is the most significant byte of the word.
    function automatic logic [31:0] extend_load(
        input logic [31:0] word,
        input logic [2:0]  ltype,
        input logic [1:0]  lsb
    );
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] res_v;
        case (lsb)
            2'd0:    byte_v = word[31:24];
            2'd1:    byte_v = word[23:16];
            2'd2:    byte_v = word[15:8];
            2'd3:    byte_v = word[7:0];
            default: byte_v = word[31:24];
        endcase
        half_v = lsb[1] ? word[15:0] : word[31:16];
        case (ltype)
            3'b001:  res_v = {{24{byte_v[7]}}, byte_v};
            3'b010:  res_v = {24'd0, byte_v};
            3'b011:  res_v = {{16{half_v[15]}}, half_v};
            3'b100:  res_v = {16'd0, half_v};
            default: res_v = word;
        endcase
        return res_v;
    endfunction

    logic [N-1:0] next_data_s;
    logic         next_we_s;
    logic         capture_s;

    // Next-state data/enable selection for the write-back register.
    always_comb begin
        next_data_s = data_from_alu;
        if (select_wb == 1'b1) begin
            next_data_s = extend_load(data_from_memory, load_type, addr_lsb);
        end else begin
            next_data_s = data_from_alu;
        end
        next_we_s = rf_we_in & ~flush & (rd_in != {RF_ADDR_W{1'b0}});
        capture_s = flush | ~stall;
    end

    // Output register: reset beats flush, flush beats stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_to_rf <= {N{1'b0}};
            rd_out     <= {RF_ADDR_W{1'b0}};
            rf_we_out  <= 1'b0;
        end else if (capture_s) begin
            data_to_rf <= next_data_s;
            rd_out     <= rd_in;
            rf_we_out  <= next_we_s;
        end else begin
            data_to_rf <= data_to_rf;
            rd_out     <= rd_out;
            rf_we_out  <= rf_we_out;
        end
    end

endmodule

// File: tb/tb_write_back_stage.sv
// Scoreboard bench for write_back_stage: expected outputs are queued as each
// cycle is driven and popped/compared one edge later.
module tb_write_back_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, rf_we_in;
    logic [0:0]  select_wb;
    logic [31:0] data_from_memory, data_from_alu, data_to_rf;
    logic [2:0]  load_type;
    logic [1:0]  addr_lsb;
    logic [4:0]  rd_in, rd_out;
    logic        rf_we_out;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    exp_t sb[$];
    exp_t model;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    write_back_stage #(.N(32), .RF_ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .data_from_memory(data_from_memory), .data_from_alu(data_from_alu),
        .select_wb(select_wb), .load_type(load_type), .addr_lsb(addr_lsb),
        .rd_in(rd_in), .rf_we_in(rf_we_in), .stall(stall), .flush(flush),
        .data_to_rf(data_to_rf), .rd_out(rd_out), .rf_we_out(rf_we_out)
    );

    // Reference load extension written with shifts rather than lane tables.
    function automatic logic [31:0] ref_ext(input logic [31:0] m, input logic [2:0] lt,
                                            input logic [1:0] lsb);
        logic [31:0] b, h;
        b = (m >> (8 * (3 - int'(lsb)))) & 32'h0000_00FF;
        h = (m >> (lsb[1] ? 0 : 16)) & 32'h0000_FFFF;
        if (lt == 3'b001) return b[7]  ? (b | 32'hFFFF_FF00) : b;
        if (lt == 3'b010) return b;
        if (lt == 3'b011) return h[15] ? (h | 32'hFFFF_0000) : h;
        if (lt == 3'b100) return h;
        return m;
    endfunction

    // Advance the model one edge from the current inputs, queue it, clock the DUT.
    task automatic apply();
        if (rst) begin
            model = '0;
        end else if (flush || !stall) begin
            model.data = select_wb[0] ? ref_ext(data_from_memory, load_type, addr_lsb)
                                      : data_from_alu;
            model.rd   = rd_in;
            model.we   = rf_we_in && !flush && (rd_in != 5'd0);
        end
        sb.push_back(model);
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [31:0] mem, input logic [31:0] alu, input logic sel,
                          input logic [2:0] lt, input logic [1:0] lsb, input logic [4:0] rd,
                          input logic we, input logic st, input logic fl);
        data_from_memory = mem; data_from_alu = alu; select_wb = sel;
        load_type = lt; addr_lsb = lsb; rd_in = rd; rf_we_in = we; stall = st; flush = fl;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        set_in(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, 3'd0, 2'd0, 5'd7, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            apply();
            total++;
            if (sb.size() == 0) begin bad++; $display("FAIL reset: scoreboard empty"); end
            else begin
                e = sb.pop_front();
                if ({data_to_rf, rd_out, rf_we_out} !== e || e !== '0) begin
                    bad++;
                    $display("FAIL reset: got %h/%0d/%b want 0/0/0", data_to_rf, rd_out, rf_we_out);
                end
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_alu();
        exp_t e;
        logic [31:0] vals [3] = '{32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_0001};
        logic [4:0]  rds  [3] = '{5'd3, 5'd31, 5'd17};
        for (int i = 0; i < 3; i++) begin
            set_in(32'hA5A5_A5A5, vals[i], 1'b0, 3'b001, 2'd3, rds[i], 1'b1, 1'b0, 1'b0);
            apply();
            total++;
            if (sb.size() == 0) begin bad++; $display("FAIL alu: scoreboard empty"); end
            else begin
                e = sb.pop_front();
                if ({data_to_rf, rd_out, rf_we_out} !== e) begin
                    bad++;
                    $display("FAIL alu[%0d]: got %h/%0d/%b want %h/%0d/%b", i,
                             data_to_rf, rd_out, rf_we_out, e.data, e.rd, e.we);
                end
            end
        end
    endtask

    task automatic test_load_ext();
        exp_t e;
        logic [31:0] mem [10] = '{32'h80F1_7F02, 32'h80F1_7F02, 32'h80F1_7F02, 32'h8001_FFFE,
                                  32'h8001_FFFE, 32'h8001_FFFE, 32'h1234_8081, 32'h1234_8081,
                                  32'h7F80_0102, 32'hF00F_1234};
        logic [2:0]  lt  [10] = '{3'b001, 3'b001, 3'b010, 3'b011, 3'b100, 3'b000,
                                  3'b011, 3'b001, 3'b101, 3'b111};
        logic [1:0]  ls  [10] = '{2'd0, 2'd2, 2'd1, 2'd2, 2'd0, 2'd3, 2'd3, 2'd3, 2'd1, 2'd2};
        for (int i = 0; i < 10; i++) begin
            set_in(mem[i], 32'h0BAD_0BAD, 1'b1, lt[i], ls[i], 5'd9, 1'b1, 1'b0, 1'b0);
            apply();
            total++;
            if (sb.size() == 0) begin bad++; $display("FAIL load: scoreboard empty"); end
            else begin
                e = sb.pop_front();
                if ({data_to_rf, rd_out, rf_we_out} !== e) begin
                    bad++;
                    $display("FAIL load[%0d]: got %h/%0d/%b want %h/%0d/%b", i,
                             data_to_rf, rd_out, rf_we_out, e.data, e.rd, e.we);
                end
            end
        end
    endtask

    task automatic test_r0_flush();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: set_in(32'h0, 32'h1111_1111, 1'b0, 3'd0, 2'd0, 5'd0, 1'b1, 1'b0, 1'b0);
                1: set_in(32'h0, 32'h2222_2222, 1'b0, 3'd0, 2'd0, 5'd4, 1'b1, 1'b0, 1'b0);
                2: set_in(32'h0, 32'h3333_3333, 1'b0, 3'd0, 2'd0, 5'd5, 1'b1, 1'b1, 1'b1);
                default: set_in(32'h0, 32'h4444_4444, 1'b0, 3'd0, 2'd0, 5'd6, 1'b1, 1'b0, 1'b1);
            endcase
            apply();
            total++;
            if (sb.size() == 0) begin bad++; $display("FAIL r0_flush: scoreboard empty"); end
            else begin
                e = sb.pop_front();
                if ({data_to_rf, rd_out, rf_we_out} !== e) begin
                    bad++;
                    $display("FAIL r0_flush[%0d]: got %h/%0d/%b want %h/%0d/%b", i,
                             data_to_rf, rd_out, rf_we_out, e.data, e.rd, e.we);
                end
            end
        end
    endtask

    task automatic test_stall();
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            set_in(32'h8000_0000 + i, 32'h5000_0000 + i, i[0], 3'b011, 2'(i), 5'(10 + i),
                   1'b1, (i >= 1 && i <= 3), 1'b0);
            apply();
            total++;
            if (sb.size() == 0) begin bad++; $display("FAIL stall: scoreboard empty"); end
            else begin
                e = sb.pop_front();
                if ({data_to_rf, rd_out, rf_we_out} !== e) begin
                    bad++;
                    $display("FAIL stall[%0d]: got %h/%0d/%b want %h/%0d/%b", i,
                             data_to_rf, rd_out, rf_we_out, e.data, e.rd, e.we);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            rst = (i == 1 || i == 2);
            set_in(32'hFFFF_0000, 32'h7777_0000 + i, 1'b0, 3'd0, 2'd0, 5'd12, 1'b1,
                   (i <= 2), 1'b0);
            apply();
            total++;
            if (sb.size() == 0) begin bad++; $display("FAIL reset_mid: scoreboard empty"); end
            else begin
                e = sb.pop_front();
                if ({data_to_rf, rd_out, rf_we_out} !== e) begin
                    bad++;
                    $display("FAIL reset_mid[%0d]: got %h/%0d/%b want %h/%0d/%b", i,
                             data_to_rf, rd_out, rf_we_out, e.data, e.rd, e.we);
                end
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        exp_t e;
        for (int i = 0; i < 60; i++) begin
            set_in($urandom, $urandom, 1'($urandom), 3'($urandom), 2'($urandom),
                   5'($urandom_range(0, 31)), 1'($urandom),
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
            apply();
            total++;
            if (sb.size() == 0) begin bad++; $display("FAIL random: scoreboard empty"); end
            else begin
                e = sb.pop_front();
                if ({data_to_rf, rd_out, rf_we_out} !== e) begin
                    bad++;
                    $display("FAIL random[%0d]: got %h/%0d/%b want %h/%0d/%b", i,
                             data_to_rf, rd_out, rf_we_out, e.data, e.rd, e.we);
                end
            end
        end
    endtask

    initial begin
        model = '0;
        rst = 1'b1;
        set_in(32'h0, 32'h0, 1'b0, 3'd0, 2'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        test_reset();
        test_alu();
        test_load_ext();
        test_r0_flush();
        test_stall();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/write_back_stage.md
WRITE_BACK_STAGE -- requirements
Module: write_back_stage

Interface
REQ-001 Parameter N, default 32, datapath width in bits; legal values 32 only for load extension (byte/halfword lanes assume 32).
REQ-002 Parameter RF_ADDR_W, default 5, register-file address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 data_from_memory  input  N  raw word read from data memory.
REQ-006 data_from_alu  input  N  ALU/execute result.
REQ-007 select_wb  input  1 ([0:0])  source select: 0 = ALU, 1 = memory.
REQ-008 load_type  input  3  memory extension mode: 000 word, 001 byte signed, 010 byte unsigned, 011 half signed, 100 half unsigned; 101-111 treated as word.
REQ-009 addr_lsb  input  2  low address bits of the load, selecting byte/halfword lane (big-endian, DLX).
REQ-010 rd_in  input  RF_ADDR_W  destination register index.
REQ-011 rf_we_in  input  1  instruction writes register file.
REQ-012 stall  input  1  hold stage outputs.
REQ-013 flush  input  1  squash the incoming instruction.
REQ-014 data_to_rf  output  N  registered write-back data.
REQ-015 rd_out  output  RF_ADDR_W  registered destination index.
REQ-016 rf_we_out  output  1  registered register-file write enable.

Function
REQ-017 Lane selection (big-endian): byte lane k = addr_lsb occupies bits [31-8k : 24-8k]; halfword uses addr_lsb[1] (0 -> [31:16], 1 -> [15:0]); addr_lsb[0] ignored for halfword, ignored entirely for word.
REQ-018 Byte signed: selected byte in [7:0], bits [31:8] = byte bit 7; byte unsigned: bits [31:8] = 0.
REQ-019 Half signed: selected half in [15:0], bits [31:16] = half bit 15; half unsigned: bits [31:16] = 0.
REQ-020 Next data = extended memory value when select_wb = 1, else data_from_alu unmodified (load_type, addr_lsb ignored).
REQ-021 Next enable = rf_we_in AND NOT flush AND (rd_in != 0); writes to R0 are always suppressed.
REQ-022 Latency: exactly one clk cycle from inputs to data_to_rf/rd_out/rf_we_out.
REQ-023 When stall = 1 and flush = 0, all outputs hold their previous values.
REQ-024 flush has priority over stall: flush = 1 loads rf_we_out = 0 on the next edge regardless of stall; data_to_rf and rd_out load normally.
REQ-025 No combinational path from any input to any output.

Reset
REQ-026 rst = 1 at a rising edge sets data_to_rf = 0, rd_out = 0, rf_we_out = 0; rst has priority over stall and flush.
REQ-027 Outputs remain at reset values while rst stays high; the first capture happens on the first edge with rst = 0.

Verification
REQ-028 select_wb=0, data_from_alu=0x12345678, rd_in=3, rf_we_in=1 -> next cycle data_to_rf=0x12345678, rd_out=3, rf_we_out=1.
REQ-029 select_wb=1, data_from_memory=0x80F17F02, load_type=001: addr_lsb=0 -> 0xFFFFFF80, addr_lsb=2 -> 0x0000007F; load_type=010, addr_lsb=1 -> 0x000000F1.
REQ-030 select_wb=1, data_from_memory=0x8001FFFE, load_type=011, addr_lsb=2 -> 0xFFFFFFFE; load_type=100, addr_lsb=0 -> 0x00008001; load_type=000 -> 0x8001FFFE.
REQ-031 rd_in=0, rf_we_in=1 -> rf_we_out=0; flush=1 with stall=1 -> rf_we_out=0 next cycle.
REQ-032 stall=1 for 3 cycles while inputs change -> outputs unchanged; release stall -> new values one cycle later.
REQ-033 rst asserted mid-stream with stall=1 -> next edge all outputs 0; held 0 until rst deasserted.
